// File: rtl/exchange_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : exchange_scheduler
//  Description : Iteration sequencer for the replica-exchange annealing array.
//                Per iteration: optimisation step, exp pipeline
//                (init/run/fin), then an even/odd exchange shift with
//                alternating pairing parity.
//                Optional macro EXCHANGE_SCHED_PERF_EN builds the busy-cycle
//                counter on perf_cycles; otherwise perf_cycles is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module exchange_scheduler #(
  parameter int REPLICA_NUM  = 32,
  parameter int EXP_CYCLES   = 17,
  parameter int SHIFT_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [23:0]            iter_times,
  input  logic                   abort,
  input  logic                   opt_done,
  output logic                   opt_run,
  output logic                   exp_init,
  output logic                   exp_run,
  output logic                   exp_fin,
  output logic                   exchange_shift,
  output logic [REPLICA_NUM-1:0] exchange_en,
  output logic                   parity,
  output logic [23:0]            iter_count,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            perf_cycles
);

  // One down-counter serves both the exp-run and shift phases.
  localparam int CNT_MAX = (EXP_CYCLES > SHIFT_CYCLES) ? EXP_CYCLES : SHIFT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPT      = 3'd1,
    S_EXP_INIT = 3'd2,
    S_EXP_RUN  = 3'd3,
    S_EXP_FIN  = 3'd4,
    S_XCHG     = 3'd5,
    S_NEXT     = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [23:0]            iter_times_q, iter_times_d;
  logic [23:0]            iter_count_q, iter_count_d;
  logic                   parity_q, parity_d;
  logic                   done_q, done_d;
  logic                   opt_run_q, opt_run_d;
  logic                   exp_init_q, exp_init_d;
  logic                   exp_run_q, exp_run_d;
  logic                   exp_fin_q, exp_fin_d;
  logic                   shift_q, shift_d;
  logic [REPLICA_NUM-1:0] en_q, en_d;
  logic                   busy_q, busy_d;

  // Constant pair masks: bit i marks the lower member of a pair with parity i%2.
  logic [REPLICA_NUM-1:0] mask_even, mask_odd;
  for (genvar i = 0; i < REPLICA_NUM; i++) begin : g_mask
    assign mask_even[i] = ((i % 2) == 0 && (i + 1) < REPLICA_NUM) ? 1'b1 : 1'b0;
    assign mask_odd[i]  = ((i % 2) == 1 && (i + 1) < REPLICA_NUM) ? 1'b1 : 1'b0;
  end

  // Next-state, iteration bookkeeping and registered strobe decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    iter_times_d = iter_times_q;
    iter_count_d = iter_count_q;
    parity_d     = parity_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (iter_times == 24'd0) begin
            done_d = 1'b1;
          end else begin
            iter_times_d = iter_times;
            iter_count_d = 24'd0;
            parity_d     = 1'b0;
            state_d      = S_OPT;
          end
        end
      end
      S_OPT: begin
        if (opt_done) state_d = S_EXP_INIT;
      end
      S_EXP_INIT: begin
        state_d = S_EXP_RUN;
        cnt_d   = CNT_W'(EXP_CYCLES - 1);
      end
      S_EXP_RUN: begin
        if (cnt_q == '0) state_d = S_EXP_FIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_EXP_FIN: begin
        state_d = S_XCHG;
        cnt_d   = CNT_W'(SHIFT_CYCLES - 1);
      end
      S_XCHG: begin
        if (cnt_q == '0) state_d = S_NEXT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_NEXT: begin
        iter_count_d = iter_count_q + 24'd1;
        parity_d     = ~parity_q;
        if (iter_count_d == iter_times_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_OPT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything but leaves the progress registers readable.
    if (abort) begin
      state_d      = S_IDLE;
      done_d       = 1'b0;
      cnt_d        = cnt_q;
      iter_times_d = iter_times_q;
      iter_count_d = iter_count_q;
      parity_d     = parity_q;
    end

    // Strobes are decoded from the next state so they register alongside it.
    opt_run_d  = (state_d == S_OPT) && (state_q != S_OPT);
    exp_init_d = (state_d == S_EXP_INIT);
    exp_run_d  = (state_d == S_EXP_RUN);
    exp_fin_d  = (state_d == S_EXP_FIN);
    shift_d    = (state_d == S_XCHG);
    en_d       = shift_d ? (parity_d ? mask_odd : mask_even) : '0;
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      iter_times_q <= 24'd0;
      iter_count_q <= 24'd0;
      parity_q     <= 1'b0;
      done_q       <= 1'b0;
      opt_run_q    <= 1'b0;
      exp_init_q   <= 1'b0;
      exp_run_q    <= 1'b0;
      exp_fin_q    <= 1'b0;
      shift_q      <= 1'b0;
      en_q         <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      iter_times_q <= iter_times_d;
      iter_count_q <= iter_count_d;
      parity_q     <= parity_d;
      done_q       <= done_d;
      opt_run_q    <= opt_run_d;
      exp_init_q   <= exp_init_d;
      exp_run_q    <= exp_run_d;
      exp_fin_q    <= exp_fin_d;
      shift_q      <= shift_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
    end
  end

  assign opt_run        = opt_run_q;
  assign exp_init       = exp_init_q;
  assign exp_run        = exp_run_q;
  assign exp_fin        = exp_fin_q;
  assign exchange_shift = shift_q;
  assign exchange_en    = en_q;
  assign parity         = parity_q;
  assign iter_count     = iter_count_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef EXCHANGE_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter: clears on an accepted start, saturates, holds when idle.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start && !abort) perf_d = 32'd0;
    else if (busy_q && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  // Perf counter register.
  always_ff @(posedge clk) begin
    if (reset) perf_q <= 32'd0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/exchange_scheduler.md
Name: exchange_scheduler

Overview:
Iteration sequencer for the replica-exchange annealing array. Each iteration it runs one optimisation step on all replica nodes, then the shared exp pipeline (init/run/fin), then one ordering exchange shift for even- or odd-pair replicas, alternating parity between iterations. It sits between the bus-interface run command (run_write/run_times) and the node array's control inputs.

Parameters:
replica_num, 32, number of replica nodes; width of exchange_en
exp_cycles, 17, cycles exp_run stays high per iteration (≥1)
shift_cycles, 8, cycles exchange_shift stays high per iteration (≥1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a run of iter_times iterations
iter_times  in  24  iteration count, sampled when start is accepted
abort  in  1  synchronous stop request
opt_done  in  1  pulse from node array: optimisation step complete
opt_run  out  1  one-cycle pulse launching an optimisation step
exp_init  out  1  exp pipeline init strobe
exp_run  out  1  exp pipeline run enable
exp_fin  out  1  exp pipeline finish strobe
exchange_shift  out  1  ordering/distance exchange shift enable
exchange_en  out  replica_num  per-replica exchange-attempt mask for the current iteration
parity  out  1  current pairing parity: 0 = pairs (0,1),(2,3)…; 1 = pairs (1,2),(3,4)…
iter_count  out  24  iterations completed in the current run
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run completes normally

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: state=IDLE. All outputs 0: opt_run, exp_*, exchange_shift, exchange_en, parity, iter_count, busy, done.
- States: IDLE, OPT, EXP_INIT, EXP_RUN, EXP_FIN, XCHG, NEXT.
- IDLE: on start with iter_times≠0, latch iter_times, clear iter_count, set parity=0, and go to OPT. On start with iter_times=0, pulse done the next cycle and stay IDLE. start is ignored when busy=1.
- OPT: opt_run is high for exactly the first cycle in OPT. Wait for opt_done; an opt_done in that same first cycle is accepted. opt_done in any other state is ignored. No timeout.
- EXP_INIT: exp_init high for 1 cycle, then EXP_RUN.
- EXP_RUN: exp_run high for exactly exp_cycles consecutive cycles (down-counter), then EXP_FIN.
- EXP_FIN: exp_fin high for 1 cycle, then XCHG.
- XCHG: exchange_shift high for exactly shift_cycles consecutive cycles.
  - exchange_en is valid for the same cycles and is 0 otherwise.
  - Bit i of exchange_en is 1 iff (i mod 2)==parity and i+1<replica_num. The bit marks the lower member of each pair.
- NEXT, 1 cycle:
  - iter_count += 1 and parity toggles.
  - If the new iter_count equals the latched iter_times: go to IDLE and pulse done in the same cycle the IDLE state is entered.
  - Otherwise go to OPT.
- Latency per iteration: 1 (OPT entry) + wait + 1 + exp_cycles + 1 + shift_cycles + 1 cycles.
- abort: takes priority over all transitions except reset.
  - Next cycle: state=IDLE and all strobes 0.
  - No done pulse.
  - iter_count and parity hold their values for readback.
- start and abort in the same cycle: abort wins; the start is dropped.
- iter_count saturates only at the latched iter_times (24-bit). iter_times=0xFFFFFF runs the full count without wrap.
- Strobes are registered outputs. They never glitch and never overlap; at most one of opt_run/exp_*/exchange_shift is high in any cycle.

Optional Feature:
- Macro: EXCHANGE_SCHED_PERF_EN.
- With the macro: output perf_cycles (32 bits) counts cycles with busy=1. It clears on accepted start, saturates at 0xFFFFFFFF, and holds after done or abort. Reset value is 0.
- Without the macro: the port is present and tied to 0, and no counter is built.

Test Plan:
- Basic run: reset, start with iter_times=2; opt_done 3 cycles after each opt_run.
  - 2 opt_run pulses; exp_run high 17 cycles and exchange_shift high 8 cycles per iteration.
  - exchange_en=0x55555555 in iteration 1 and 0x2AAAAAAA in iteration 2.
  - done pulses once; iter_count=2; parity=0.
- Zero count: start with iter_times=0 → done one cycle later; busy stays 0; no opt_run.
- Start while busy: a second start during EXP_RUN is ignored; the run completes with its original iter_times=1.
- Abort: abort asserted during XCHG of iteration 1 (iter_times=5) → next cycle state IDLE, exchange_shift=0, exchange_en=0, no done, iter_count=0, parity=0.
- Reset mid-run: reset asserted in OPT → all outputs 0 the next cycle, including iter_count and parity. A new start of 1 then completes normally.
- Odd replica count: replica_num=5, 2 iterations → exchange_en=0b00101 then 0b01010.
- Perf (macro on): iter_times=1 with opt_done 3 cycles after opt_run → perf_cycles = total busy cycles (OPT 4 + 1 + 17 + 1 + 8 + 1 = 32).
